// File: rtl/avalon.sv
// Status timing adapter: buffers {data, error} beats from a non-stallable source in a first-word-fall-through FIFO.
// Latency: 1 cycle from an accepted in_valid to out_valid; outputs come from registered state only.
// Backpressure: out_ready stalls the head; when full with no pop, the beat is dropped, pulsed on overflow and counted.
module avalon #(
    parameter int DATA_W = 40,
    parameter int ERR_W  = 7,
    parameter int DEPTH  = 4,
    parameter int AW     = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ERR_W-1:0]  in_error,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ERR_W-1:0]  out_error,
    input  logic              out_ready,
    output logic [AW:0]       fill_level,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count
);
    localparam int PW = DATA_W + ERR_W;

    logic [PW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          full;
    logic          push;
    logic          pop;
    logic          drop;

    assign full      = (fill_level == (AW+1)'(DEPTH));
    assign out_valid = (fill_level != '0);
    assign pop       = out_valid & out_ready;
    // A full FIFO still accepts a beat when the head leaves on the same edge.
    assign push      = in_valid & (~full | pop);
    assign drop      = in_valid & ~push;

    assign {out_data, out_error} = mem[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp         <= '0;
            rp         <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wp] <= {in_data, in_error};
                wp      <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            case ({push, pop})
                2'b10:   fill_level <= fill_level + 1'b1;
                2'b01:   fill_level <= fill_level - 1'b1;
                default: fill_level <= fill_level;
            endcase
            overflow <= drop;
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_avalon.sv
// Bench for avalon: directed plan scenarios plus random traffic checked against a queue-based model.
// Two instances share stimulus: default counter width and a 4-bit counter for saturation.
module tb_avalon;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [39:0] in_data;
    logic [6:0]  in_error;
    logic        out_ready;

    logic        a_valid, b_valid;
    logic [39:0] a_data, b_data;
    logic [6:0]  a_err, b_err;
    logic [2:0]  a_fill, b_fill;
    logic        a_ovf, b_ovf;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [46:0] q[$];
    bit          ovf_exp;
    int          drops;

    avalon dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
        .out_valid(a_valid), .out_data(a_data), .out_error(a_err), .out_ready(out_ready),
        .fill_level(a_fill), .overflow(a_ovf), .drop_count(a_cnt)
    );

    avalon #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
        .out_valid(b_valid), .out_data(b_data), .out_error(b_err), .out_ready(out_ready),
        .fill_level(b_fill), .overflow(b_ovf), .drop_count(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        int sat_a;
        int sat_b;
        sat_a = (drops > 65535) ? 65535 : drops;
        sat_b = (drops > 15) ? 15 : drops;
        chk("a_valid", 64'(a_valid), 64'(q.size() != 0));
        chk("b_valid", 64'(b_valid), 64'(q.size() != 0));
        chk("a_fill", 64'(a_fill), 64'(q.size()));
        chk("b_fill", 64'(b_fill), 64'(q.size()));
        chk("a_ovf", 64'(a_ovf), 64'(ovf_exp));
        chk("b_ovf", 64'(b_ovf), 64'(ovf_exp));
        chk("a_cnt", 64'(a_cnt), 64'(sat_a));
        chk("b_cnt", 64'(b_cnt), 64'(sat_b));
        if (q.size() != 0) begin
            chk("a_head", 64'({a_data, a_err}), 64'(q[0]));
            chk("b_head", 64'({b_data, b_err}), 64'(q[0]));
        end
    endtask

    // One clock of traffic: model decides pop/push/drop from pre-edge occupancy.
    task automatic step(input bit iv, input logic [39:0] d, input logic [6:0] e, input bit rdy);
        bit pop, push, drop;
        in_valid  = iv;
        in_data   = d;
        in_error  = e;
        out_ready = rdy;
        pop  = (q.size() != 0) && rdy;
        push = iv && ((q.size() < DEPTH) || pop);
        drop = iv && !push;
        @(posedge clk);
        #1;
        if (pop) void'(q.pop_front());
        if (push) q.push_back({d, e});
        ovf_exp = drop;
        if (drop) drops++;
        check_model();
    endtask

    task automatic model_clear();
        q.delete();
        ovf_exp = 1'b0;
        drops   = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(a_valid), 64'd0);
        chk({tag, "_data"}, 64'(a_data), 64'd0);
        chk({tag, "_err"}, 64'(a_err), 64'd0);
        chk({tag, "_fill"}, 64'(a_fill), 64'd0);
        chk({tag, "_ovf"}, 64'(a_ovf), 64'd0);
        chk({tag, "_cnt"}, 64'(a_cnt), 64'd0);
        chk({tag, "_b_cnt"}, 64'(b_cnt), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_clear();
        check_zero("rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [39:0] rd;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_error  = '0;
        out_ready = 1'b0;
        model_clear();
        #2;
        check_zero("por");
        @(negedge clk);
        reset = 1'b0;

        // Pass-through with ready held high.
        for (int i = 0; i < 3; i++) step(0, '0, '0, 1);
        step(1, 40'h00_1234_5678, 7'h05, 1);
        chk("pt_data", 64'(a_data), 64'h00_1234_5678);
        chk("pt_err", 64'(a_err), 64'h05);
        step(0, '0, '0, 1);
        chk("pt_empty", 64'(a_fill), 64'd0);

        // Fill, overflow, drain.
        for (int i = 1; i <= 4; i++) step(1, 40'(i), 7'(i), 0);
        chk("full_fill", 64'(a_fill), 64'd4);
        for (int i = 0; i < 3; i++) step(1, 40'(8'hA0 + i), '0, 0);
        chk("ovf_cnt3", 64'(a_cnt), 64'd3);
        chk("ovf_head", 64'(a_data), 64'd1);
        // Full plus simultaneous push and pop: no drop.
        step(1, 40'h5, 7'h5, 1);
        chk("simul_fill", 64'(a_fill), 64'd4);
        chk("simul_cnt", 64'(a_cnt), 64'd3);
        for (int i = 2; i <= 5; i++) begin
            chk("drain_seq", 64'(a_data), 64'(i));
            step(0, '0, '0, 1);
        end
        chk("drain_empty", 64'(a_valid), 64'd0);

        // Saturation of the narrow counter: 20 more drops.
        for (int i = 0; i < 4; i++) step(1, 40'(i + 16), '0, 0);
        for (int i = 0; i < 20; i++) step(1, 40'hDEAD, 7'h7F, 0);
        chk("sat_b", 64'(b_cnt), 64'd15);
        chk("sat_a", 64'(a_cnt), 64'd23);
        step(0, '0, '0, 0);
        chk("sat_hold", 64'(b_cnt), 64'd15);

        // Mid-stream reset between edges.
        do_reset();
        for (int i = 0; i < 3; i++) step(1, 40'(i + 40'h30), 7'(i), 0);
        in_valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        model_clear();
        check_zero("mid");
        #2;
        reset = 1'b0;
        step(1, 40'h77, 7'h11, 1);
        chk("post_rst_head", 64'({a_data, a_err}), 64'({40'h77, 7'h11}));
        step(0, '0, '0, 1);
        chk("post_rst_empty", 64'(a_valid), 64'd0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            rd = {8'($urandom), 32'($urandom)};
            step(($urandom_range(0, 99) < 70), rd, 7'($urandom),
                 ($urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 80 : 40)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
